// File: rtl/datamover_ldst_arbiter.sv
// Round-robin arbiter merging NB_LD load and NB_ST store channels onto one TCDM port, with an in-order ID FIFO for load responses.
// Optional perf counters are enabled by defining DATAMOVER_ARB_PERF_EN.
module datamover_ldst_arbiter #(
  parameter int NB_LD           = 2,
  parameter int NB_ST           = 1,
  parameter int DW              = 64,
  parameter int AW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  // Store port width; stays at least 1 so the ports remain legal when NB_ST = 0
  parameter int STW             = (NB_ST > 0) ? NB_ST : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  input  logic                                enable_i,
  input  logic [NB_LD-1:0]                    ld_req_i,
  output logic [NB_LD-1:0]                    ld_gnt_o,
  input  logic [NB_LD*AW-1:0]                 ld_add_i,
  output logic [NB_LD-1:0]                    ld_r_valid_o,
  output logic [DW-1:0]                       ld_r_data_o,
  input  logic [STW-1:0]                      st_req_i,
  output logic [STW-1:0]                      st_gnt_o,
  input  logic [STW*AW-1:0]                   st_add_i,
  input  logic [STW*DW-1:0]                   st_data_i,
  input  logic [STW*DW/8-1:0]                 st_be_i,
  output logic                                tcdm_req_o,
  input  logic                                tcdm_gnt_i,
  output logic [AW-1:0]                       tcdm_add_o,
  output logic                                tcdm_wen_o,
  output logic [DW/8-1:0]                     tcdm_be_o,
  output logic [DW-1:0]                       tcdm_data_o,
  input  logic                                tcdm_r_valid_i,
  input  logic [DW-1:0]                       tcdm_r_data_i,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                spurious_o,
  output logic [31:0]                         perf_gnt_o,
  output logic [31:0]                         perf_stall_o
);

  localparam int N   = NB_LD + NB_ST;
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int IDW = (NB_LD > 1) ? $clog2(NB_LD) : 1;
  localparam int FAW = $clog2(MAX_OUTSTANDING);
  localparam int CW  = FAW + 1;
  localparam int BW  = DW / 8;

  logic [N-1:0]   w_req, w_elig;
  logic [PW-1:0]  w_sel;
  logic           w_any, w_is_ld, w_hs, w_push, w_pop;
  logic           w_full, w_empty, w_full_eff;
  logic [IDW-1:0] w_head;

  logic [IDW-1:0] r_id_mem [MAX_OUTSTANDING];
  logic [FAW-1:0] r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  r_rr;

  genvar gi;
  generate
    for (gi = 0; gi < NB_LD; gi++) begin : g_ld_req
      assign w_req[gi] = ld_req_i[gi];
    end
    for (gi = 0; gi < NB_ST; gi++) begin : g_st_req
      assign w_req[NB_LD+gi] = st_req_i[gi];
    end
    // A pop in the same cycle frees a slot, so a full FIFO still accepts a load
    for (gi = 0; gi < N; gi++) begin : g_elig
      if (gi < NB_LD) begin : g_ld
        assign w_elig[gi] = w_req[gi] & enable_i & ~w_full_eff;
      end else begin : g_st
        assign w_elig[gi] = w_req[gi] & enable_i;
      end
    end
  endgenerate

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(MAX_OUTSTANDING));
  assign w_pop      = tcdm_r_valid_i & ~w_empty;
  assign w_full_eff = w_full & ~w_pop;
  assign w_head     = r_id_mem[r_rptr];

  // Lowest offset from r_rr wins, so scan offsets from the far end downwards
  always_comb begin
    int idx;
    w_sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(r_rr) + k;
      if (idx >= N) idx = idx - N;
      if (w_elig[idx]) w_sel = PW'(idx);
    end
  end

  assign w_any   = |w_elig;
  assign w_is_ld = w_any & (int'(w_sel) < NB_LD);
  assign w_hs    = w_any & tcdm_gnt_i;
  assign w_push  = w_hs & w_is_ld;

  always_comb begin
    int s;
    tcdm_add_o  = '0;
    tcdm_wen_o  = 1'b0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    s           = 0;
    if (w_is_ld) begin
      tcdm_add_o = ld_add_i[int'(w_sel)*AW +: AW];
      tcdm_wen_o = 1'b1;
      tcdm_be_o  = '1;
    end else if (w_any) begin
      s           = int'(w_sel) - NB_LD;
      tcdm_add_o  = st_add_i[s*AW +: AW];
      tcdm_be_o   = st_be_i[s*BW +: BW];
      tcdm_data_o = st_data_i[s*DW +: DW];
    end
  end

  always_comb begin
    ld_gnt_o     = '0;
    st_gnt_o     = '0;
    ld_r_valid_o = '0;
    for (int c = 0; c < NB_LD; c++) begin
      ld_gnt_o[c]     = w_hs & (int'(w_sel) == c);
      ld_r_valid_o[c] = w_pop & (int'(w_head) == c);
    end
    for (int c = 0; c < NB_ST; c++) begin
      st_gnt_o[c] = w_hs & (int'(w_sel) == NB_LD + c);
    end
  end

  assign tcdm_req_o    = w_any;
  assign ld_r_data_o   = tcdm_r_data_i;
  assign outstanding_o = r_count;
  assign spurious_o    = tcdm_r_valid_i & w_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_id_mem[r_wptr] <= w_sel[IDW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr    <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_hs) r_rr <= (w_sel == PW'(N - 1)) ? '0 : w_sel + 1'b1;
    end
  end

`ifdef DATAMOVER_ARB_PERF_EN
  logic [31:0] r_perf_gnt, r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_gnt   <= '0;
      r_perf_stall <= '0;
    end else if (clear_i) begin
      r_perf_gnt   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_hs && r_perf_gnt != '1) r_perf_gnt <= r_perf_gnt + 1'b1;
      if ((|w_req) && !w_hs && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_gnt_o   = r_perf_gnt;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_gnt_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule
